// File: rtl/flash_line_cache.sv
// flash_line_cache: direct-mapped line-fill read cache in front of the QSPI
// data-request port. Line data lives in an external dual-port SRAM (port 0
// fills, port 1 serves hits); tags and valid bits are held in flops.
// Optional feature: define FLASH_LINE_CACHE_CRITICAL_WORD_FIRST_EN to start
// each line fill at the requested word and wrap through the line.
module flash_line_cache #(
    parameter int SRAM_ADDRESS_SIZE = 9,
    parameter int LINE_WORDS_LOG2   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flashCache_readEnable,
    input  logic [23:0]                  flashCache_address,
    input  logic [3:0]                   flashCache_byteSelect,
    input  logic                         flashCache_invalidate,
    output logic [31:0]                  flashCache_dataRead,
    output logic                         flashCache_busy,
    output logic [23:0]                  dataRequest_address,
    output logic                         dataRequest_enable,
    input  logic [31:0]                  dataRequest_data,
    input  logic                         dataRequest_dataValid,
    output logic                         sram_clk0,
    output logic                         sram_csb0,
    output logic                         sram_web0,
    output logic [3:0]                   sram_wmask0,
    output logic [SRAM_ADDRESS_SIZE-1:0] sram_addr0,
    output logic [31:0]                  sram_din0,
    input  logic [31:0]                  sram_dout0,
    output logic                         sram_clk1,
    output logic                         sram_csb1,
    output logic [SRAM_ADDRESS_SIZE-1:0] sram_addr1,
    input  logic [31:0]                  sram_dout1
);

    localparam int OFF_W = LINE_WORDS_LOG2;
    localparam int IDX_W = SRAM_ADDRESS_SIZE - LINE_WORDS_LOG2;
    localparam int TAG_W = 22 - SRAM_ADDRESS_SIZE;
    localparam int LINES = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WRITE,
        UPDATE
    } state_t;

    state_t             state_reg, state_next;
    logic [TAG_W-1:0]   tag_reg, tag_next;
    logic [IDX_W-1:0]   index_reg, index_next;
    logic [OFF_W-1:0]   counter_reg, counter_next;
    logic [OFF_W-1:0]   start_reg, start_next;
    logic [31:0]        data_reg, data_next;
    logic [LINES-1:0]   valid_reg, valid_next;
    logic               inval_pending_reg, inval_pending_next;
    logic               tag_we;

    logic [TAG_W-1:0]   tag_store [LINES];

    logic [OFF_W-1:0]   req_offset;
    logic [IDX_W-1:0]   req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [OFF_W-1:0]   counter_inc;
    logic [OFF_W-1:0]   fill_start;
    logic [LINES-1:0]   line_hit;
    logic               hit;

    // Byte lanes, low address bits and the fill-port read data are not needed.
    logic unused_inputs;
    assign unused_inputs = ^{flashCache_byteSelect, sram_dout0, flashCache_address[1:0]};

    assign req_offset  = flashCache_address[OFF_W+1:2];
    assign req_index   = flashCache_address[SRAM_ADDRESS_SIZE+1:OFF_W+2];
    assign req_tag     = flashCache_address[23:SRAM_ADDRESS_SIZE+2];
    assign counter_inc = counter_reg + 1'b1;

`ifdef FLASH_LINE_CACHE_CRITICAL_WORD_FIRST_EN
    assign fill_start = req_offset;
`else
    assign fill_start = '0;
`endif

    // Per-line tag compare; the requested line's result is the hit.
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line_hit
            assign line_hit[gi] = valid_reg[gi] && (tag_store[gi] == req_tag);
        end
    endgenerate
    assign hit = line_hit[req_index];

    // Static SRAM wiring: both ports share the system clock, fills write whole words.
    assign sram_clk0           = clk;
    assign sram_clk1           = clk;
    assign sram_wmask0         = 4'b1111;
    assign sram_addr0          = {index_reg, counter_reg};
    assign sram_din0           = data_reg;
    assign sram_addr1          = {req_index, req_offset};
    assign flashCache_dataRead = sram_dout1;
    assign dataRequest_address = {tag_reg, index_reg, counter_reg, 2'b00};

    // Control and fill-context registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            tag_reg           <= '0;
            index_reg         <= '0;
            counter_reg       <= '0;
            start_reg         <= '0;
            data_reg          <= '0;
            valid_reg         <= '0;
            inval_pending_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            tag_reg           <= tag_next;
            index_reg         <= index_next;
            counter_reg       <= counter_next;
            start_reg         <= start_next;
            data_reg          <= data_next;
            valid_reg         <= valid_next;
            inval_pending_reg <= inval_pending_next;
        end
    end

    // Tag store: loaded once a line fill completes; contents only matter with valid set.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_store[index_reg] <= tag_reg;
        end
    end

    // Next-state and output decode for lookup and line fill.
    always_comb begin
        state_next         = state_reg;
        tag_next           = tag_reg;
        index_next         = index_reg;
        counter_next       = counter_reg;
        start_next         = start_reg;
        data_next          = data_reg;
        valid_next         = flashCache_invalidate ? '0 : valid_reg;
        inval_pending_next = inval_pending_reg | flashCache_invalidate;
        tag_we             = 1'b0;
        flashCache_busy    = 1'b0;
        dataRequest_enable = 1'b0;
        sram_csb0          = 1'b1;
        sram_web0          = 1'b1;
        sram_csb1          = 1'b1;

        case (state_reg)
            IDLE: begin
                inval_pending_next = 1'b0;
                if (flashCache_readEnable) begin
                    if (hit) begin
                        sram_csb1 = 1'b0;
                    end else begin
                        flashCache_busy    = 1'b1;
                        tag_next           = req_tag;
                        index_next         = req_index;
                        counter_next       = fill_start;
                        start_next         = fill_start;
                        inval_pending_next = flashCache_invalidate;
                        state_next         = REQUEST;
                    end
                end
            end
            REQUEST: begin
                flashCache_busy    = 1'b1;
                dataRequest_enable = 1'b1;
                if (dataRequest_dataValid) begin
                    data_next  = dataRequest_data;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                flashCache_busy = 1'b1;
                sram_csb0       = 1'b0;
                sram_web0       = 1'b0;
                counter_next    = counter_inc;
                // The fill is done once the counter wraps back to where it started.
                state_next      = (counter_inc == start_reg) ? UPDATE : REQUEST;
            end
            UPDATE: begin
                flashCache_busy = 1'b1;
                tag_we          = 1'b1;
                // A line fetched across an invalidate may hold stale flash data.
                if (!flashCache_invalidate && !inval_pending_reg) begin
                    valid_next[index_reg] = 1'b1;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/flash_line_cache.md
# flash_line_cache

Direct-mapped, line-fill read cache between the flash-cache read interface and the QSPI data-request port. It stores flash contents in the dual-port SRAM and keeps tags and valid bits in flops. On a miss it fetches the whole line from the QSPI device word by word through SRAM port 0. Hits are served from SRAM port 1 with single-cycle latency. It replaces the pass-through flash buffer wherever flash-backed instruction or data fetch needs real caching.

## Interface
- SRAM_ADDRESS_SIZE, 9: SRAM word-address width (cache size = 2^SRAM_ADDRESS_SIZE words).
- LINE_WORDS_LOG2, 3: log2 of words per line; lines = 2^(SRAM_ADDRESS_SIZE-LINE_WORDS_LOG2); must be < SRAM_ADDRESS_SIZE.

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flashCache_readEnable  in  1  read request, held until busy is low.
- flashCache_address  in  24  byte address; [1:0] ignored.
- flashCache_byteSelect  in  4  accepted, ignored (full word returned).
- flashCache_invalidate  in  1  single-cycle pulse: invalidate all lines.
- flashCache_dataRead  out  32  read data (= sram_dout1).
- flashCache_busy  out  1  request not yet satisfiable; requester holds address.
- dataRequest_address  out  24  word-aligned flash fetch address.
- dataRequest_enable  out  1  fetch request.
- dataRequest_data  in  32  fetched word.
- dataRequest_dataValid  in  1  one-cycle strobe qualifying dataRequest_data.
- sram_clk0/csb0/web0/wmask0/addr0/din0, sram_dout0: port 0 (fill write); sram_clk0 = clk, wmask0 = 4'b1111, dout0 unused.
- sram_clk1/csb1/addr1, sram_dout1: port 1 (hit read); sram_clk1 = clk.

## Operation
- Address split (word address = address[23:2]): offset = [LINE_WORDS_LOG2+1:2], index = [SRAM_ADDRESS_SIZE+1:LINE_WORDS_LOG2+2], tag = [23:SRAM_ADDRESS_SIZE+2]. SRAM address = {index, offset}.
- Hit = valid[index] && tag_store[index] == tag; evaluated combinationally in IDLE.
- States: IDLE, REQUEST, WRITE, UPDATE.
- IDLE: readEnable && hit -> csb1 = 0, addr1 = {index,offset}, busy = 0. readEnable && miss -> busy = 1, latch tag/index, word counter = 0, go REQUEST.
- REQUEST: dataRequest_enable = 1, dataRequest_address = {tag, index, counter, 2'b00}. On dataValid, capture data, go WRITE.
- WRITE: csb0 = 0, web0 = 0, addr0 = {index, counter}, din0 = captured word; counter += 1 (wraps mod line). Last word -> UPDATE, else REQUEST.
- UPDATE: tag_store[index] = tag; valid[index] = 1 unless an invalidate arrived during the fill. Go IDLE.
- busy = 1 in REQUEST, WRITE and UPDATE, and in IDLE on a miss.
- Invalidate: clears all valid bits at the next edge in any state. A fill in progress completes its SRAM writes but does not set valid.
- dataValid outside REQUEST is ignored. A readEnable/address change while busy is a protocol violation; the latched fill continues.
- Outputs not listed for a state: dataRequest_enable = 0, csb0 = 1, web0 = 1, csb1 = 1.

## Timing
- Reset (rst = 0, async): state IDLE, all valid = 0, counter = 0, dataRequest_enable = 0, busy = 0 (until a miss), csb0 = 1, web0 = 1, csb1 = 1, addr0 = 0, din0 = 0.
- Hit: request at cycle T, flashCache_dataRead valid at T+1, busy never asserted.
- Miss: busy from T through UPDATE. IDLE re-lookup hits one cycle after UPDATE; data is valid the cycle after that.
- Per word: dataRequest_enable high until and including the dataValid cycle, then low for exactly one cycle (WRITE).
- Miss penalty = 2^LINE_WORDS_LOG2 × (device latency + 1) + 2 cycles.

## Configuration
- FLASH_LINE_CACHE_CRITICAL_WORD_FIRST_EN defined: counter starts at the requested offset and wraps through the line; total fill length is unchanged.
- Undefined: fill always starts at offset 0 and runs in ascending order.

## Test plan
- Reset, read 0x000010 -> busy = 1, requests 0x000000..0x00001C ascending, addr0 0..7, then dataRead = word at 0x10 one cycle after busy falls.
- Read 0x000014 after that fill -> no busy, csb1 = 0, data on the next cycle, no dataRequest_enable.
- Read 0x000810 (same index 0, tag 1) -> refill of index 0; subsequent read 0x000010 misses again.
- Pulse invalidate during fill of 0x000000 -> fill completes 8 writes; immediate re-read of 0x000000 misses.
- Assert rst mid-fill (after 3 words) -> dataRequest_enable and busy 0 immediately; re-read misses and refetches all 8 words.
- Macro defined, read 0x00001C -> request order 0x1C, 0x00, 0x04, ... 0x18; dataRead = word at 0x1C.
